alu_addsub_seq: RTL
===================

ALU_ADDSUB_SEQ -- requirements
Module: alu_addsub_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand/result width in bits (legal: 4..64).
REQ-002 The block SHALL have parameter CHUNK, default 4, bits resolved per CALC cycle; WIDTH % CHUNK == 0 required.
REQ-003 The block SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, request; sampled only in IDLE.
REQ-006 The block SHALL have port op, input, 1, 0 = add, 1 = subtract (a - b); sampled with start.
REQ-007 The block SHALL have ports a and b, input, WIDTH, signed operands; sampled with start.
REQ-008 The block SHALL have port result, output, WIDTH, registered two's-complement result, modulo 2^WIDTH.
REQ-009 The block SHALL have port flags, output, 4, registered {N, Z, C, V}.
REQ-010 The block SHALL have port busy, output, 1, high while in CALC or DONE.
REQ-011 The block SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-012 FSM states SHALL be IDLE, CALC and DONE.
- IDLE->CALC on start.
- CALC->DONE after NCH = WIDTH/CHUNK cycles.
- DONE->IDLE unconditionally.
REQ-013 On the start edge the block SHALL latch a, op, and B = op ? ~b : b, and SHALL clear the chunk counter; carry-in SHALL be op.
REQ-014 Each CALC cycle SHALL resolve chunk k (bits k*CHUNK+CHUNK-1 .. k*CHUNK) by carry-lookahead (G = A&B, P = A^B) using the registered carry from chunk k-1, store the sum bits, register the chunk carry-out, and increment k.
REQ-015 Result and flags SHALL update only on the edge completing the final chunk; done SHALL be set on that edge and cleared on the next; latency is NCH edges from the start edge to done high.
REQ-016 N SHALL equal result MSB; Z SHALL equal (result == 0).
REQ-017 C SHALL equal the carry-out of the MSB; for subtract, C = 1 means no borrow (a >= b unsigned).
REQ-018 V SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-019 start, a, b and op SHALL be ignored while busy; an operation in flight SHALL NOT be aborted or altered.
REQ-020 start SHALL be ignored in DONE; the earliest accepted restart is the cycle after done.
REQ-021 result and flags SHALL hold their last values between operations.
REQ-022 Intermediate chunk sums SHALL NOT be visible on result before completion.
REQ-023 If WIDTH == CHUNK, then NCH = 1 and done SHALL assert one edge after the start edge.

Reset
REQ-024 reset SHALL force state = IDLE and SHALL clear result, flags, done, busy, the chunk counter, the carry register and the operand registers.
REQ-025 reset SHALL have priority over start and over any in-progress CALC; an operation interrupted by reset SHALL produce no done.
REQ-026 The first start after reset is released SHALL be accepted normally.

Structure
REQ-027 Shared package alu_pkg SHALL hold:
- OP_ADD/OP_SUB encodings;
- FSM state encodings;
- flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
REQ-028 Chunk adder SHALL be sub-module alu_cla_chunk (parameter CHUNK; inputs a, b, cin; outputs sum, cout, c_msb_in), purely combinational, instantiated once.
REQ-029 The chunk counter SHALL be clog2(NCH) bits wide, with a minimum width of 1.

Verification (WIDTH=16, CHUNK=4, latency 4 unless stated)
REQ-030 Add 0x7FFF + 0x0001 SHALL yield result 0x8000, N=1, Z=0, C=0, V=1, with done exactly 4 edges after start.
REQ-031 Sub 0x0005 - 0x0005 SHALL yield result 0x0000, N=0, Z=1, C=1, V=0.
REQ-032 Sub 0x0000 - 0x0001 SHALL yield result 0xFFFF, N=1, C=0, V=0; sub 0x8000 - 0x0001 SHALL yield result 0x7FFF, C=1, V=1.
REQ-033 Start add 0x1234 + 0x1111, then pulse start with 0xFFFF - 0x0001 two cycles later: the block SHALL yield a single done, result 0x2345, and the second request SHALL be ignored.
REQ-034 Start sub, assert reset on the 2nd CALC cycle: done SHALL stay 0, result and flags SHALL be 0, busy SHALL be 0; a new add 0x0003 + 0x0004 SHALL yield 0x0007.
REQ-035 With WIDTH=8, CHUNK=8, sub 0x80 - 0x7F SHALL yield result 0x01, V=1, C=1, with done 1 edge after start.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings for the sequential chunked add/subtract ALU
package alu_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_cla_chunk.sv
// rtl/alu_cla_chunk.sv - combinational carry-lookahead adder for one CHUNK-bit slice
module alu_cla_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK:0]   carry;
    logic             acc;
    logic             prod;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is the flat sum-of-products of generate/propagate terms, not a ripple chain.
    always_comb begin
        carry    = '0;
        carry[0] = cin;
        acc      = 1'b0;
        prod     = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            acc  = g[i];
            prod = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc  = acc | (prod & g[j]);
                prod = prod & p[j];
            end
            acc        = acc | (prod & cin);
            carry[i+1] = acc;
        end
    end

    assign sum      = p ^ carry[CHUNK-1:0];
    assign cout     = carry[CHUNK];
    assign c_msb_in = carry[CHUNK-1];

endmodule

// File: rtl/alu_addsub_seq.sv
// rtl/alu_addsub_seq.sv - multi-cycle add/subtract resolving CHUNK bits per cycle
module alu_addsub_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             done
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] K_LAST = CW'(NCH - 1);

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    k;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] sum_next;
    logic             carry_reg;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             chunk_c_msb;
    logic [3:0]       flags_next;
    logic             last_chunk;

    assign last_chunk = (k == K_LAST);
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_CALC;
            ST_CALC: if (last_chunk) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    alu_cla_chunk #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .a       (a_reg[int'(k)*CHUNK +: CHUNK]),
        .b       (b_reg[int'(k)*CHUNK +: CHUNK]),
        .cin     (carry_reg),
        .sum     (chunk_sum),
        .cout    (chunk_cout),
        .c_msb_in(chunk_c_msb)
    );

    // The final chunk holds the MSB, so its internal carries give C and V directly.
    always_comb begin
        sum_next                        = sum_reg;
        sum_next[int'(k)*CHUNK +: CHUNK] = chunk_sum;
        flags_next                      = '0;
        flags_next[FLAG_N]              = sum_next[WIDTH-1];
        flags_next[FLAG_Z]              = (sum_next == '0);
        flags_next[FLAG_C]              = chunk_cout;
        flags_next[FLAG_V]              = chunk_c_msb ^ chunk_cout;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k         <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            result    <= '0;
            flags     <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= (op == OP_SUB) ? ~b : b;
                        carry_reg <= op;
                        sum_reg   <= '0;
                        k         <= '0;
                    end
                end
                ST_CALC: begin
                    sum_reg   <= sum_next;
                    carry_reg <= chunk_cout;
                    if (last_chunk) begin
                        k      <= '0;
                        result <= sum_next;
                        flags  <= flags_next;
                        done   <= 1'b1;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
